// File: rtl/k12a_fetch_seq_pkg.sv
// Shared K12a sequencer types: FSM states, decoded skip kinds and the skip-register select code.
// Pure declarations, so there is no latency and no backpressure.
package k12a_fetch_seq_pkg;

    typedef enum logic [1:0] {
        SKIP_SEL_HOLD        = 2'd0,
        SKIP_SEL_0           = 2'd1,
        SKIP_SEL_CONDITION   = 2'd2,
        SKIP_SEL_CONDITION_N = 2'd3
    } skip_sel_t;

    typedef enum logic [2:0] {
        S_FETCH_HI = 3'd0,
        S_FETCH_LO = 3'd1,
        S_EXEC     = 3'd2,
        S_MEMWAIT  = 3'd3,
        S_HALT     = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        SK_NONE   = 2'd0,
        SK_COND   = 2'd1,
        SK_COND_N = 2'd2
    } skip_kind_t;

    localparam int WAIT_CNT_W = 8;

    function automatic skip_sel_t kind_to_sel(input skip_kind_t kind);
        case (kind)
            SK_COND:   return SKIP_SEL_CONDITION;
            SK_COND_N: return SKIP_SEL_CONDITION_N;
            default:   return SKIP_SEL_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/k12a_fetch_seq_if.sv
// Memory request bus between the sequencer (master) and the memory (slave).
// The request is held until the memory answers with mem_ready.
interface k12a_fetch_seq_if;
    logic mem_req;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/k12a_fetch_seq_mem_timeout.sv
// Memory wait-state counter with a sticky bus_error; timeout is flagged in the same cycle as the last wait.
// It never stalls the requester; it only reports when a request has waited MEM_TIMEOUT cycles.
module k12a_mem_timeout
    import k12a_fetch_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic cpu_clock,
    input  logic reset_n,
    input  logic mem_req,
    input  logic mem_ready,
    input  logic clr,
    output logic timeout,
    output logic bus_error
);

    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  bus_error_q, bus_error_d;

    // The wait that would take the count to MEM_TIMEOUT is the one that times out.
    assign timeout   = mem_req && !mem_ready && (wait_cnt_q == LIMIT);
    assign bus_error = bus_error_q;

    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        bus_error_d = bus_error_q | timeout;
        if (clr || mem_ready) begin
            wait_cnt_d = '0;
        end else if (mem_req) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

endmodule

// File: rtl/k12a_fetch_seq.sv
// K12a sequencer: 16-bit instruction as hi/lo byte fetch, then execute/skip, data access, halt.
// 3 cycles per zero-wait instruction; every memory access stalls in place until mem_ready.
module k12a_fetch_seq
    import k12a_fetch_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                     cpu_clock,
    input  logic                     reset_n,
    input  logic                     run_en,
    input  logic                     skip,
    input  skip_kind_t               dec_skip_kind,
    input  logic                     dec_mem,
    input  logic                     dec_halt,
    input  logic                     resume,
    k12a_fetch_seq_if.master         mem,
    output logic                     ir_hi_load,
    output logic                     ir_lo_load,
    output logic                     pc_inc,
    output logic                     exec_en,
    output skip_sel_t                skip_sel,
    output logic                     halted,
    output logic                     bus_error
);

    seq_state_t state_q, state_d;
    logic       mem_req_c, mem_addr_sel_c;
    logic       timeout;

    assign mem.mem_req      = mem_req_c;
    assign mem.mem_addr_sel = mem_addr_sel_c;

    // Any state change starts a fresh wait window for the counter.
    k12a_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
        .cpu_clock (cpu_clock),
        .reset_n   (reset_n),
        .mem_req   (mem_req_c),
        .mem_ready (mem.mem_ready),
        .clr       (state_d != state_q),
        .timeout   (timeout),
        .bus_error (bus_error)
    );

    always_comb begin
        state_d        = state_q;
        mem_req_c      = 1'b0;
        mem_addr_sel_c = 1'b0;
        ir_hi_load     = 1'b0;
        ir_lo_load     = 1'b0;
        pc_inc         = 1'b0;
        exec_en        = 1'b0;
        skip_sel       = SKIP_SEL_HOLD;
        halted         = 1'b0;
        case (state_q)
            S_FETCH_HI: begin
                if (run_en || bus_error) begin
                    mem_req_c = 1'b1;
                    if (mem.mem_ready) begin
                        ir_hi_load = 1'b1;
                        pc_inc     = 1'b1;
                        state_d    = S_FETCH_LO;
                    end
                end
            end
            S_FETCH_LO: begin
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_lo_load = 1'b1;
                    pc_inc     = 1'b1;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (skip) begin
                    // A suppressed instruction is the only thing that consumes the skip flag.
                    skip_sel = SKIP_SEL_0;
                    state_d  = S_FETCH_HI;
                end else if (dec_halt) begin
                    state_d = S_HALT;
                end else if (dec_mem) begin
                    mem_req_c      = 1'b1;
                    mem_addr_sel_c = 1'b1;
                    if (mem.mem_ready) begin
                        exec_en = 1'b1;
                        state_d = S_FETCH_HI;
                    end else begin
                        state_d = S_MEMWAIT;
                    end
                end else begin
                    exec_en  = 1'b1;
                    skip_sel = kind_to_sel(dec_skip_kind);
                    state_d  = S_FETCH_HI;
                end
            end
            S_MEMWAIT: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                if (mem.mem_ready) begin
                    exec_en = 1'b1;
                    state_d = S_FETCH_HI;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume && !bus_error) begin
                    state_d = S_FETCH_HI;
                end
            end
            default: state_d = S_FETCH_HI;
        endcase
        if (timeout) begin
            state_d = S_HALT;
        end
    end

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH_HI;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
